// File: rtl/imem_loadable.sv
// ---------------------------------------------------------------------------
// imem_loadable
//   Byte-addressed, big-endian instruction memory with a byte-serial program
//   load port. Fetch is 1-cycle latency and fully pipelined. The load port is
//   run by a two-state FSM (RUN / LOAD).
//
// Optional feature macro: IMEM_BOUNDS_CHECK_EN
//   defined   : out-of-range fetches return NOP_WORD with fetch_fault = 1
//   undefined : addresses and byte lanes wrap modulo DEPTH_BYTES, fault = 0
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   load_start        pulse: begin load at byte 0 (ignored while loading)
//   load_valid/data   program byte stream
//   load_last         marks the final byte (with load_valid)
//   load_ready, busy  high while in LOAD
//   load_done         one-cycle pulse on load completion
//   fetch_req/addr    word fetch request (byte address)
//   fetch_valid       response to the previous-cycle request
//   instruction       fetched word, mem[idx] in bits 31:24
//   fetch_misalign    fetch_addr[1:0] != 0
//   fetch_fault       out-of-range fetch (bounds-check build only)
// ---------------------------------------------------------------------------
module imem_loadable #(
    parameter int          ADDR_W      = 32,
    parameter int          DEPTH_BYTES = 256,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              busy,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [31:0]       instruction,
    output logic              fetch_misalign,
    output logic              fetch_fault
);

    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic {ST_RUN, ST_LOAD} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_ptr;
    logic            r_load_ready;
    logic            r_load_done;
    logic            r_fetch_valid;
    logic [31:0]     r_instr;
    logic            r_misalign;
    logic [7:0]      r_mem [DEPTH_BYTES];

    logic            w_accept;
    logic            w_final;
    logic            w_fetch;
    logic            w_fault;
    logic [AW-1:0]   w_i0, w_i1, w_i2, w_i3;
    logic [31:0]     w_word;

    assign w_accept = (r_state == ST_LOAD) && load_valid;
    // Final byte: explicit last, or the top of the array (no wrap on load).
    assign w_final  = w_accept && (load_last || (r_ptr == AW'(DEPTH_BYTES - 1)));
    // Fetches are only serviced in RUN; requests during LOAD are dropped.
    assign w_fetch  = (r_state == ST_RUN) && fetch_req;

    // Byte lane indices wrap at the array end through AW-bit truncation.
    assign w_i0   = fetch_addr[AW-1:0];
    assign w_i1   = w_i0 + AW'(1);
    assign w_i2   = w_i0 + AW'(2);
    assign w_i3   = w_i0 + AW'(3);
    assign w_word = {r_mem[w_i0], r_mem[w_i1], r_mem[w_i2], r_mem[w_i3]};

`ifdef IMEM_BOUNDS_CHECK_EN
    // Fault on any address bit above the array, or a word running off the end.
    assign w_fault = ((fetch_addr >> AW) != '0) || (w_i0 > AW'(DEPTH_BYTES - 4));

    logic r_fault;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_fault <= 1'b0;
        else if (w_fetch) r_fault <= w_fault;
    end
    assign fetch_fault = r_fault;
`else
    logic w_unused_hi;
    assign w_fault     = 1'b0;
    assign w_unused_hi = ^fetch_addr;
    assign fetch_fault = 1'b0;
`endif

    // Load FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_ptr        <= '0;
            r_load_ready <= 1'b0;
            r_load_done  <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (load_start) begin
                        r_state      <= ST_LOAD;
                        r_ptr        <= '0;
                        r_load_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_final) begin
                        r_state      <= ST_RUN;
                        r_ptr        <= '0;
                        r_load_ready <= 1'b0;
                        r_load_done  <= 1'b1;
                    end else if (w_accept) begin
                        r_ptr <= r_ptr + AW'(1);
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Storage is intentionally not reset so a program survives rst_n.
    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_ptr] <= load_data;
    end

    // Fetch response; data/flags hold when no request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_valid <= 1'b0;
            r_instr       <= '0;
            r_misalign    <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch;
            if (w_fetch) begin
                r_instr    <= w_fault ? NOP_WORD : w_word;
                r_misalign <= |fetch_addr[1:0];
            end
        end
    end

    assign load_ready     = r_load_ready;
    assign busy           = r_load_ready;
    assign load_done      = r_load_done;
    assign fetch_valid    = r_fetch_valid;
    assign instruction    = r_instr;
    assign fetch_misalign = r_misalign;

endmodule

// File: tb/tb_imem_loadable.sv
module tb_imem_loadable;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_data = 8'h00;
    logic        load_last = 1'b0;
    logic        load_ready, load_done, busy;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = 32'h0;
    logic        fetch_valid;
    logic [31:0] instruction;
    logic        fetch_misalign, fetch_fault;

    int total = 0;
    int bad   = 0;

    imem_loadable #(.ADDR_W(32), .DEPTH_BYTES(256), .NOP_WORD(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .busy(busy), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .instruction(instruction),
        .fetch_misalign(fetch_misalign), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        mis;
        logic        flt;
    } fvec_t;

    fvec_t tv[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input string nm);
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        chk({nm, " ready"}, {31'b0, load_ready}, 32'd1);
        chk({nm, " busy"},  {31'b0, busy},       32'd1);
    endtask

    // Stream bytes; optional fetch_req at byte fetch_at must be dropped.
    task automatic feed(input logic [7:0] b[$], input bit use_last, input int fetch_at,
                        input string nm);
        for (int i = 0; i < b.size(); i++) begin
            load_valid = 1'b1;
            load_data  = b[i];
            load_last  = use_last && (i == b.size() - 1);
            fetch_req  = (i == fetch_at);
            fetch_addr = 32'h0;
            tick;
            if (i == fetch_at) chk({nm, " drop_fetch"}, {31'b0, fetch_valid}, 32'd0);
            if (i < b.size() - 1) chk({nm, " done_early"}, {31'b0, load_done}, 32'd0);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        fetch_req  = 1'b0;
        chk({nm, " done"},     {31'b0, load_done},  32'd1);
        chk({nm, " ready_lo"}, {31'b0, load_ready}, 32'd0);
        chk({nm, " busy_lo"},  {31'b0, busy},       32'd0);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic em,
                         input logic ef, input string nm);
        fetch_req  = 1'b1;
        fetch_addr = a;
        tick;
        fetch_req  = 1'b0;
        chk({nm, " valid"}, {31'b0, fetch_valid},    32'd1);
        chk({nm, " instr"}, instruction,             ei);
        chk({nm, " mis"},   {31'b0, fetch_misalign}, {31'b0, em});
        chk({nm, " flt"},   {31'b0, fetch_fault},    {31'b0, ef});
    endtask

    initial begin
        logic [7:0] q[$];
        bit bc;
`ifdef IMEM_BOUNDS_CHECK_EN
        bc = 1'b1;
`else
        bc = 1'b0;
`endif
        tv[0] = '{32'h0000_0000, 32'h0102_0304, 1'b0, 1'b0};
        tv[1] = '{32'h0000_0004, 32'h0506_0708, 1'b0, 1'b0};
        tv[2] = '{32'h0000_0002, 32'h0304_0506, 1'b1, 1'b0};
        tv[3] = '{32'h0000_0001, 32'h0203_0405, 1'b1, 1'b0};
        tv[4] = '{32'h0000_0003, 32'h0405_0607, 1'b1, 1'b0};
        tv[5] = bc ? '{32'h0000_0100, 32'h0, 1'b0, 1'b1} : '{32'h0000_0100, 32'h0102_0304, 1'b0, 1'b0};
        tv[6] = bc ? '{32'h0000_0106, 32'h0, 1'b1, 1'b1} : '{32'h0000_0106, 32'h0708_0000, 1'b1, 1'b0};

        // Reset state
        tick;
        chk("rst instr", instruction, 32'h0);
        chk("rst outs", {25'b0, fetch_valid, fetch_misalign, fetch_fault, load_ready,
                         load_done, busy, 1'b0}, 32'h0);
        rst_n = 1'b1;
        tick;

        // Basic 4-byte program
        start_load("t1");
        q = '{8'h21, 8'h49, 8'h00, 8'h64};
        feed(q, 1'b1, -1, "t1");
        fetch(32'h0, 32'h2149_0064, 1'b0, 1'b0, "t1 f0");
        chk("t1 done_once", {31'b0, load_done}, 32'd0);
        tick;
        chk("hold valid", {31'b0, fetch_valid}, 32'd0);
        chk("hold instr", instruction, 32'h2149_0064);

        // 8 bytes, then back-to-back table fetches; tv[6] wraps into bytes 8/9
        // which are loaded as 00 here.
        start_load("t2");
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00, 8'h00};
        feed(q, 1'b1, -1, "t2");
        for (int i = 0; i < 7; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = tv[i].addr;
            tick;
            chk($sformatf("tv%0d valid", i), {31'b0, fetch_valid}, 32'd1);
            chk($sformatf("tv%0d instr", i), instruction, tv[i].instr);
            chk($sformatf("tv%0d mis", i), {31'b0, fetch_misalign}, {31'b0, tv[i].mis});
            chk($sformatf("tv%0d flt", i), {31'b0, fetch_fault}, {31'b0, tv[i].flt});
        end
        fetch_req = 1'b0;
        tick;
        chk("t2 idle valid", {31'b0, fetch_valid}, 32'd0);

        // Fetch and load_start together: fetch served, FSM enters LOAD
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        load_start = 1'b1;
        tick;
        fetch_req  = 1'b0;
        load_start = 1'b0;
        chk("sim valid", {31'b0, fetch_valid}, 32'd1);
        chk("sim instr", instruction, 32'h0506_0708);
        chk("sim busy", {31'b0, busy}, 32'd1);

        // Full 256-byte load without load_last, byte i = 255-i
        q.delete();
        for (int i = 0; i < 256; i++) q.push_back(8'(255 - i));
        feed(q, 1'b0, 100, "t3");
        // First RUN cycle after LOAD
        fetch(32'd252, 32'h0302_0100, 1'b0, 1'b0, "t3 f252");
        chk("t3 done_once", {31'b0, load_done}, 32'd0);
        if (bc) fetch(32'd254, 32'h0, 1'b1, 1'b1, "t3 f254");
        else    fetch(32'd254, 32'h0100_FFFE, 1'b1, 1'b0, "t3 f254");

        // Reset mid-load after 3 bytes
        start_load("t4");
        load_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_data = 8'hAA + 8'(i);
            tick;
        end
        rst_n = 1'b0;
        #1;
        chk("t4 rst busy", {31'b0, busy}, 32'd0);
        chk("t4 rst ready", {31'b0, load_ready}, 32'd0);
        load_valid = 1'b0;
        tick;
        chk("t4 rst done", {31'b0, load_done}, 32'd0);
        rst_n = 1'b1;
        tick;
        start_load("t5");
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        feed(q, 1'b1, -1, "t5");
        fetch(32'h0, 32'h1122_3344, 1'b0, 1'b0, "t5 f0");
        fetch(32'h4, 32'hFBFA_F9F8, 1'b0, 1'b0, "t5 f4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
